// File: rtl/vga_timing_640_480.sv
// 640x480@60 VGA timing generator: pixel-rate enable, h/v counters, sync and address decodes.
// Optional 8-bit frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_640_480 #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_sclr,
  output logic       o_px_clk,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_hsync_en,
  output logic       o_vsync_en,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] o_frame_cnt
`endif
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HMax      = 10'(HTotal - 1);
  localparam logic [9:0] VMax      = 10'(VTotal - 1);
  localparam logic [9:0] HVis      = 10'(H_VISIBLE);
  localparam logic [9:0] VVis      = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncBeg  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncBeg  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      hcnt_q, hcnt_d;
  logic [9:0]      vcnt_q, vcnt_d;
  logic            px_tick, h_wrap, v_wrap;

  always_comb begin
    px_tick = (div_q == DivMax);
    h_wrap  = (hcnt_q == HMax);
    v_wrap  = (vcnt_q == VMax);
    div_d   = px_tick ? '0 : div_q + 1'b1;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (px_tick) begin
      if (h_wrap) begin
        hcnt_d = '0;
        vcnt_d = v_wrap ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
    // Synchronous clear overrides any tick or wrap in the same cycle.
    if (i_sclr) begin
      div_d  = '0;
      hcnt_d = '0;
      vcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (i_sclr) begin
      frame_cnt_d = '0;
    end else if (px_tick && h_wrap && v_wrap) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

  always_comb begin
    o_px_clk      = px_tick;
    o_hsync_en    = (hcnt_q >= HSyncBeg) && (hcnt_q < HSyncEnd);
    o_vsync_en    = (vcnt_q >= VSyncBeg) && (vcnt_q < VSyncEnd);
    o_hsync       = ~o_hsync_en;
    o_vsync       = ~o_vsync_en;
    o_haddr_en    = (hcnt_q < HVis);
    o_vaddr_en    = (vcnt_q < VVis);
    o_hidx        = o_haddr_en ? hcnt_q : 10'd0;
    o_vidx        = o_vaddr_en ? vcnt_q[8:0] : 9'd0;
    o_frame_start = px_tick && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  end

endmodule

// File: tb/tb_vga_timing_640_480.sv
// Bench for vga_timing_640_480: a full-size instance plus a shrunken-timing instance, both
// checked every cycle against an arithmetic model driven by clocks elapsed since the last clear.
module tb_vga_timing_640_480;

  localparam int SCd = 2;
  localparam int SHv = 6, SHf = 2, SHs = 2, SHb = 2;
  localparam int SVv = 3, SVf = 1, SVs = 1, SVb = 1;
  localparam int SFrame = SCd * (SHv + SHf + SHs + SHb) * (SVv + SVf + SVs + SVb);  // 144 clks

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclr = 1'b0;

  logic       d_px, d_hs, d_vs, d_hse, d_vse, d_ha, d_va, d_fs;
  logic [9:0] d_hidx;
  logic [8:0] d_vidx;
  logic       s_px, s_hs, s_vs, s_hse, s_vse, s_ha, s_va, s_fs;
  logic [9:0] s_hidx;
  logic [8:0] s_vidx;
  logic [26:0] d_vec, s_vec;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] d_fc, s_fc;
`endif

  assign d_vec = {d_px, d_hs, d_vs, d_hse, d_vse, d_ha, d_va, d_hidx, d_vidx, d_fs};
  assign s_vec = {s_px, s_hs, s_vs, s_hse, s_vse, s_ha, s_va, s_hidx, s_vidx, s_fs};

  vga_timing_640_480 u_dut_def (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_sclr       (sclr),
    .o_px_clk     (d_px),
    .o_hsync      (d_hs),
    .o_vsync      (d_vs),
    .o_hsync_en   (d_hse),
    .o_vsync_en   (d_vse),
    .o_haddr_en   (d_ha),
    .o_vaddr_en   (d_va),
    .o_hidx       (d_hidx),
    .o_vidx       (d_vidx),
    .o_frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .o_frame_cnt  (d_fc)
`endif
  );

  vga_timing_640_480 #(
    .CLK_DIV  (SCd),
    .H_VISIBLE(SHv), .H_FRONT(SHf), .H_SYNC(SHs), .H_BACK(SHb),
    .V_VISIBLE(SVv), .V_FRONT(SVf), .V_SYNC(SVs), .V_BACK(SVb)
  ) u_dut_small (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_sclr       (sclr),
    .o_px_clk     (s_px),
    .o_hsync      (s_hs),
    .o_vsync      (s_vs),
    .o_hsync_en   (s_hse),
    .o_vsync_en   (s_vse),
    .o_haddr_en   (s_ha),
    .o_vaddr_en   (s_va),
    .o_hidx       (s_hidx),
    .o_vidx       (s_vidx),
    .o_frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .o_frame_cnt  (s_fc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t_m = 0;
  bit chk_en = 1'b0;

  // Clocks elapsed since reset release or the last synchronous clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_m <= 0;
    else if (sclr) t_m <= 0;
    else t_m <= t_m + 1;
  end

  function automatic logic [26:0] model(input int t, input int cd, input int hv, input int hf,
                                        input int hs, input int hb, input int vv, input int vf,
                                        input int vs, input int vb);
    int ht = hv + hf + hs + hb;
    int vt = vv + vf + vs + vb;
    int n  = t / cd;
    int h  = n % ht;
    int v  = (n / ht) % vt;
    logic px  = ((t % cd) == cd - 1);
    logic hse = (h >= hv + hf) && (h < hv + hf + hs);
    logic vse = (v >= vv + vf) && (v < vv + vf + vs);
    logic ha  = (h < hv);
    logic va  = (v < vv);
    logic [9:0] hidx = ha ? 10'(h) : 10'd0;
    logic [8:0] vidx = va ? 9'(v) : 9'd0;
    logic fs = px && (h == 0) && (v == 0);
    return {px, ~hse, ~vse, hse, vse, ha, va, hidx, vidx, fs};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0d time=%0t", name, got, exp, t_m, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("def_outs", 32'(d_vec), 32'(model(t_m, 4, 640, 16, 96, 48, 480, 10, 2, 33)));
      check("small_outs", 32'(s_vec), 32'(model(t_m, SCd, SHv, SHf, SHs, SHb, SVv, SVf, SVs, SVb)));
`ifdef VGA_FRAME_CNT_EN
      check("def_frame_cnt", 32'(d_fc), 32'((t_m / 4 / 420000) % 256));
      check("small_frame_cnt", 32'(s_fc), 32'((t_m / SFrame) % 256));
`endif
    end
  end

  initial begin
    int cnt_ha, cnt_hs, hs_first, l0, l1, first_px, last_fs, nfs;
    cnt_ha = 0; cnt_hs = 0; hs_first = -1; l0 = -1; l1 = -1; first_px = -1;
    last_fs = -1; nfs = 0;

    repeat (2) @(negedge clk);
    check("rst_px", 32'(d_px), 0);
    check("rst_hsync", 32'(d_hs), 1);
    check("rst_vsync", 32'(d_vs), 1);
    check("rst_hsync_en", 32'(d_hse), 0);
    check("rst_haddr_en", 32'(d_ha), 1);
    check("rst_vaddr_en", 32'(d_va), 1);
    check("rst_hidx", 32'(d_hidx), 0);
    check("rst_vidx", 32'(d_vidx), 0);
    check("rst_frame_start", 32'(d_fs), 0);
    chk_en = 1'b1;
    #1 rst_n = 1'b1;

    // First line and a bit of the second on the full-size instance.
    for (int i = 1; i <= 3300; i++) begin
      @(negedge clk);
      if (i == 2) check("px_clk2", 32'(d_px), 0);
      if (i == 3) begin
        check("px_clk3", 32'(d_px), 1);
        check("fs_clk3", 32'(d_fs), 1);
      end
      if (i == 4) begin
        check("hidx_clk4", 32'(d_hidx), 1);
        check("px_clk4", 32'(d_px), 0);
      end
      if (i == 7) check("px_clk7", 32'(d_px), 1);
      if (i == 11) check("px_clk11", 32'(d_px), 1);
      if (i == 3203) check("fs_line1", 32'(d_fs), 0);
      if (i <= 3200) begin
        if (d_px && d_ha) cnt_ha++;
        if (d_px && !d_hs) cnt_hs++;
        if (!d_hs && hs_first < 0) hs_first = i;
      end
      if (d_px && d_ha && d_hidx == 10'd0) begin
        if (l0 < 0) l0 = i;
        else if (l1 < 0) l1 = i;
      end
    end
    check("haddr_ticks", 32'(cnt_ha), 640);
    check("hsync_ticks", 32'(cnt_hs), 96);
    check("hsync_start_clk", 32'(hs_first), 2624);
    check("line_period", 32'(l1 - l0), 3200);

    // Clear coincident with the px tick at hcnt=655.
    for (int i = 0; i < 4000 && (t_m % 3200) != 2623; i++) @(negedge clk);
    check("at655_px", 32'(d_px), 1);
    check("at655_hsync", 32'(d_hs), 1);
    check("at655_haddr", 32'(d_ha), 0);
    #1 sclr = 1'b1;
    @(negedge clk);
    #1 sclr = 1'b0;
    check("sclr_px", 32'(d_px), 0);
    check("sclr_hsync", 32'(d_hs), 1);
    check("sclr_haddr", 32'(d_ha), 1);
    check("sclr_hidx", 32'(d_hidx), 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (d_px && first_px < 0) first_px = i;
    end
    check("sclr_next_px", 32'(first_px), 3);

    @(negedge clk);
    #1 sclr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("sclr_hold_px", 32'(d_px), 0);
      check("sclr_hold_small_px", 32'(s_px), 0);
    end
    #1 sclr = 1'b0;

    // Random clears and asynchronous resets landing mid-line/mid-frame.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(1, 300)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end else begin
        #1 sclr = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1 sclr = 1'b0;
      end
    end

    // 257+ frames on the small instance.
    @(negedge clk);
    #1 sclr = 1'b1;
    @(negedge clk);
    #1 sclr = 1'b0;
    for (int i = 1; i <= 257 * SFrame + 50; i++) begin
      @(negedge clk);
      if (i == 62) begin
        check("blank_haddr", 32'(s_ha), 0);
        check("blank_hidx", 32'(s_hidx), 0);
        check("blank_vidx", 32'(s_vidx), 2);
        check("blank_hsync", 32'(s_hs), 1);
      end
`ifdef VGA_FRAME_CNT_EN
      if (i == 256 * SFrame - 1) check("fc_255", 32'(s_fc), 255);
      if (i == 257 * SFrame + 3) check("fc_wrap_1", 32'(s_fc), 1);
`endif
      if (s_fs) begin
        if (last_fs >= 0) check("fs_period", 32'(i - last_fs), SFrame);
        last_fs = i;
        nfs++;
      end
    end
    check("fs_count", 32'(nfs), 258);

`ifdef VGA_FRAME_CNT_EN
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("fc_async_rst", 32'(s_fc), 0);
    #3 rst_n = 1'b1;
`endif

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
